// File: rtl/multi_channel_pulse_timer.sv
// ============================================================================
// multi_channel_pulse_timer : bank of independent start/stop interval timers
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_channel_pulse_timer #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 16,
  parameter int INIT_VALUE = 0,
  parameter int SATURATE   = 1,
  parameter int RETRIGGER  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start_pulse,
  input  logic [NUM_CH-1:0]       stop_pulse,
  input  logic [NUM_CH-1:0]       timer_reset,
  input  logic [NUM_CH*WIDTH-1:0] cmp_value,
  output logic [NUM_CH*WIDTH-1:0] output_timer,
  output logic [NUM_CH*WIDTH-1:0] capture_value,
  output logic [NUM_CH-1:0]       capture_valid,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       timeout_pulse,
  output logic [NUM_CH-1:0]       timeout_flag,
  output logic [NUM_CH-1:0]       overflow
);

  localparam logic [WIDTH-1:0] C_INIT     = WIDTH'(INIT_VALUE);
  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
  localparam logic             C_SAT      = (SATURATE != 0);
  localparam logic             C_RETRIG   = (RETRIGGER != 0);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             capv_q, capv_d;
    logic             tp_q, tp_d;
    logic             tf_q, tf_d;
    logic             ovf_q, ovf_d;
    logic             eq_q, eq_d;
    logic [WIDTH-1:0] w_cmp;
    logic             w_eq;

    assign w_cmp = cmp_value[i*WIDTH +: WIDTH];
    assign w_eq  = (cnt_q == w_cmp);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      capv_d  = 1'b0;
      tp_d    = 1'b0;
      tf_d    = tf_q;
      ovf_d   = ovf_q;
      eq_d    = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = C_INIT;
          if (start_pulse[i]) begin
            state_d = COUNTING;
            tf_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        COUNTING: begin
          if (timer_reset[i]) begin
            state_d = IDLE;
            cnt_d   = C_INIT;
            tf_d    = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            // eq_q remembers the previous match so a held count fires only once
            eq_d = w_eq;
            if (w_eq && !eq_q) begin
              tp_d = 1'b1;
              tf_d = 1'b1;
            end
            if (stop_pulse[i]) begin
              cap_d   = cnt_q;
              capv_d  = 1'b1;
              state_d = IDLE;
              cnt_d   = C_INIT;
              eq_d    = 1'b0;
            end else if (start_pulse[i] && C_RETRIG) begin
              cnt_d = C_INIT;
              tp_d  = 1'b0;
              tf_d  = 1'b0;
              ovf_d = 1'b0;
              eq_d  = 1'b0;
            end else if (cnt_q == C_ALL_ONES) begin
              if (C_SAT) begin
                cnt_d = cnt_q;
              end else begin
                cnt_d = '0;
                ovf_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= C_INIT;
        cap_q   <= '0;
        capv_q  <= 1'b0;
        tp_q    <= 1'b0;
        tf_q    <= 1'b0;
        ovf_q   <= 1'b0;
        eq_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cap_q   <= cap_d;
        capv_q  <= capv_d;
        tp_q    <= tp_d;
        tf_q    <= tf_d;
        ovf_q   <= ovf_d;
        eq_q    <= eq_d;
      end
    end

    assign output_timer[i*WIDTH +: WIDTH]  = cnt_q;
    assign capture_value[i*WIDTH +: WIDTH] = cap_q;
    assign capture_valid[i]                = capv_q;
    assign running[i]                      = (state_q == COUNTING);
    assign timeout_pulse[i]                = tp_q;
    assign timeout_flag[i]                 = tf_q;
    assign overflow[i]                     = ovf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_pulse_timer.sv
// ============================================================================
// tb_multi_channel_pulse_timer : directed self-checking bench for the timer bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_pulse_timer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default configuration: 4 x 16 bit, saturating, no retrigger
  logic [3:0]  m_start, m_stop, m_trst;
  logic [63:0] m_cmp, m_timer, m_cap;
  logic [3:0]  m_capv, m_run, m_tp, m_tf, m_ovf;

  // 4 bit, wrapping, retrigger
  logic       w_start, w_stop, w_trst;
  logic [3:0] w_cmp, w_timer, w_cap;
  logic       w_capv, w_run, w_tp, w_tf, w_ovf;

  // 4 bit, saturating, no retrigger, init 2
  logic       s_start, s_stop, s_trst;
  logic [3:0] s_cmp, s_timer, s_cap;
  logic       s_capv, s_run, s_tp, s_tf, s_ovf;

  int total = 0;
  int bad   = 0;

  multi_channel_pulse_timer #(
    .NUM_CH(4), .WIDTH(16), .INIT_VALUE(0), .SATURATE(1), .RETRIGGER(0)
  ) dut_m (
    .clk(clk), .rst(rst),
    .start_pulse(m_start), .stop_pulse(m_stop), .timer_reset(m_trst),
    .cmp_value(m_cmp), .output_timer(m_timer), .capture_value(m_cap),
    .capture_valid(m_capv), .running(m_run), .timeout_pulse(m_tp),
    .timeout_flag(m_tf), .overflow(m_ovf)
  );

  multi_channel_pulse_timer #(
    .NUM_CH(1), .WIDTH(4), .INIT_VALUE(0), .SATURATE(0), .RETRIGGER(1)
  ) dut_w (
    .clk(clk), .rst(rst),
    .start_pulse(w_start), .stop_pulse(w_stop), .timer_reset(w_trst),
    .cmp_value(w_cmp), .output_timer(w_timer), .capture_value(w_cap),
    .capture_valid(w_capv), .running(w_run), .timeout_pulse(w_tp),
    .timeout_flag(w_tf), .overflow(w_ovf)
  );

  multi_channel_pulse_timer #(
    .NUM_CH(1), .WIDTH(4), .INIT_VALUE(2), .SATURATE(1), .RETRIGGER(0)
  ) dut_s (
    .clk(clk), .rst(rst),
    .start_pulse(s_start), .stop_pulse(s_stop), .timer_reset(s_trst),
    .cmp_value(s_cmp), .output_timer(s_timer), .capture_value(s_cap),
    .capture_valid(s_capv), .running(s_run), .timeout_pulse(s_tp),
    .timeout_flag(s_tf), .overflow(s_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mt(input int c);
    return m_timer[c*16 +: 16];
  endfunction

  function automatic logic [15:0] mc(input int c);
    return m_cap[c*16 +: 16];
  endfunction

  initial begin
    rst = 1'b1;
    m_start = '0; m_stop = '0; m_trst = '0; m_cmp = '1;
    w_start = 1'b0; w_stop = 1'b0; w_trst = 1'b0; w_cmp = 4'd9;
    s_start = 1'b0; s_stop = 1'b0; s_trst = 1'b0; s_cmp = 4'd15;

    // reset
    tick(); tick();
    check("rst_m_timer", m_timer, 64'd0);
    check("rst_m_cap", m_cap, 64'd0);
    check("rst_m_flags", {m_capv, m_run, m_tp, m_tf, m_ovf}, 64'd0);
    check("rst_w_timer", w_timer, 64'd0);
    check("rst_s_timer", s_timer, 64'd2);
    check("rst_s_flags", {s_capv, s_run, s_tp, s_tf, s_ovf}, 64'd0);
    rst = 1'b0;

    // ch0 start/stop capture
    m_start[0] = 1'b1; tick(); m_start[0] = 1'b0;
    check("c0_run", m_run[0], 1'b1);
    check("c0_first", mt(0), 16'd0);
    repeat (10) tick();
    check("c0_cnt10", mt(0), 16'd10);
    m_stop[0] = 1'b1; tick(); m_stop[0] = 1'b0;
    check("c0_cap", mc(0), 16'd10);
    check("c0_capv", m_capv[0], 1'b1);
    check("c0_run_fall", m_run[0], 1'b0);
    check("c0_idle_timer", mt(0), 16'd0);
    tick();
    check("c0_capv_1cyc", m_capv[0], 1'b0);
    check("c0_cap_hold", mc(0), 16'd10);

    // ch1 timeout at 5
    m_cmp[16 +: 16] = 16'd5;
    m_start[1] = 1'b1; tick(); m_start[1] = 1'b0;
    repeat (5) tick();
    check("c1_at5", mt(1), 16'd5);
    check("c1_tp_early", m_tp[1], 1'b0);
    tick();
    check("c1_tp", m_tp[1], 1'b1);
    check("c1_tf", m_tf[1], 1'b1);
    tick();
    check("c1_tp_once", m_tp[1], 1'b0);
    check("c1_tf_sticky", m_tf[1], 1'b1);
    m_stop[1] = 1'b1; tick(); m_stop[1] = 1'b0;
    check("c1_tf_after_stop", m_tf[1], 1'b1);
    check("c1_cap", mc(1), 16'd7);
    m_start[1] = 1'b1; tick(); m_start[1] = 1'b0;
    check("c1_tf_cleared", m_tf[1], 1'b0);
    check("c1_run", m_run[1], 1'b1);
    m_trst[1] = 1'b1; tick(); m_trst[1] = 1'b0;
    check("c1_trst_run", m_run[1], 1'b0);
    check("c1_trst_capv", m_capv[1], 1'b0);
    check("c1_trst_timer", mt(1), 16'd0);
    m_start[1] = 1'b1; m_stop[1] = 1'b1; tick(); m_start[1] = 1'b0; m_stop[1] = 1'b0;
    check("c1_idle_start_stop_run", m_run[1], 1'b1);
    check("c1_idle_start_stop_capv", m_capv[1], 1'b0);
    m_trst[1] = 1'b1; tick(); m_trst[1] = 1'b0;

    // ch2 abort with all controls, ch3 keeps counting
    m_cmp[32 +: 16] = 16'd3;
    m_start[2] = 1'b1; m_start[3] = 1'b1; tick(); m_start = '0;
    repeat (4) tick();
    check("c2_cnt4", mt(2), 16'd4);
    check("c2_tp", m_tp[2], 1'b1);
    check("c2_tf", m_tf[2], 1'b1);
    m_start[2] = 1'b1; m_stop[2] = 1'b1; m_trst[2] = 1'b1; m_stop[0] = 1'b1;
    tick();
    m_start = '0; m_stop = '0; m_trst = '0;
    check("c2_abort_run", m_run[2], 1'b0);
    check("c2_abort_capv", m_capv[2], 1'b0);
    check("c2_abort_tf", m_tf[2], 1'b0);
    check("c2_abort_timer", mt(2), 16'd0);
    check("c2_abort_cap", mc(2), 16'd0);
    check("c3_unaffected", mt(3), 16'd5);
    check("c3_run", m_run[3], 1'b1);
    check("c0_idle_stop_capv", m_capv[0], 1'b0);
    check("c0_idle_stop_cap", mc(0), 16'd10);

    // ch3 start while counting is ignored without retrigger
    tick(); tick();
    check("c3_at7", mt(3), 16'd7);
    m_start[3] = 1'b1; tick(); m_start[3] = 1'b0;
    check("c3_no_retrig", mt(3), 16'd8);
    check("c3_still_run", m_run[3], 1'b1);

    // 4-bit wrap vs saturate, timeouts on both
    w_start = 1'b1; s_start = 1'b1; tick(); w_start = 1'b0; s_start = 1'b0;
    check("w_first", w_timer, 4'd0);
    check("s_first", s_timer, 4'd2);
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k == 10) begin
        check("w_at9", w_timer, 4'd9);
        check("w_tp_early", w_tp, 1'b0);
      end
      if (k == 11) begin
        check("w_tp", w_tp, 1'b1);
        check("w_tf", w_tf, 1'b1);
      end
      if (k == 12) check("w_tp_once", w_tp, 1'b0);
      if (k == 14) begin
        check("s_at15", s_timer, 4'd15);
        check("s_tp_early", s_tp, 1'b0);
      end
      if (k == 15) begin
        check("s_tp", s_tp, 1'b1);
        check("s_tf", s_tf, 1'b1);
      end
      if (k == 16) begin
        check("s_tp_once", s_tp, 1'b0);
        check("w_at15", w_timer, 4'd15);
        check("w_ovf_pre", w_ovf, 1'b0);
      end
      if (k == 17) begin
        check("w_wrap", w_timer, 4'd0);
        check("w_ovf", w_ovf, 1'b1);
        check("s_hold", s_timer, 4'd15);
        check("s_ovf", s_ovf, 1'b0);
        check("s_tp_held", s_tp, 1'b0);
      end
    end
    repeat (7) tick();
    check("w_at7", w_timer, 4'd7);
    w_start = 1'b1; s_start = 1'b1; tick(); w_start = 1'b0; s_start = 1'b0;
    check("w_retrig_timer", w_timer, 4'd0);
    check("w_retrig_ovf", w_ovf, 1'b0);
    check("w_retrig_tf", w_tf, 1'b0);
    check("w_retrig_run", w_run, 1'b1);
    check("s_noretrig_timer", s_timer, 4'd15);
    check("s_noretrig_tf", s_tf, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
